rnn_frame_ctrl: RTL and testbench

- Frame-level sequencer for the denoise RNN datapath.
- Streams one feature frame in word-by-word and holds it as a flat vector for the layer chain (dense/GRU).
- Runs the NUM_LAYERS layers strictly in order over a start/done handshake, with a per-layer watchdog.
- Captures the final gains and VAD, then streams the gains out word-by-word with valid/ready.

---
 rtl/rnn_frame_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_rnn_frame_ctrl.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rnn_frame_ctrl.sv
// rnn_frame_ctrl -- frame-level sequencer for the denoise RNN datapath.
//
// Loads one feature frame word-by-word into a flat vector, runs the
// NUM_LAYERS layer stages strictly in order over a start/done handshake
// (each stage guarded by a watchdog), captures the final gains and VAD,
// then streams the gains out word-by-word.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   feature word handshake; in_data word, in_last end marker
//   feature_vec         held frame, word i at [(i+1)*FIXED-1 : i*FIXED]
//   layer_start         one-hot, one-cycle start pulse per layer
//   layer_done          per-layer completion pulse
//   gains_in, vad_in    final-layer results, captured on the last done
//   out_valid/out_ready gain word handshake; out_data word, out_last on last word
//   vad_out             VAD of the last completed frame
//   busy                high while sequencing layers or draining gains
//   err_clr             clears len_err and timeout_err
//   len_err             sticky: in_last arrived on the wrong word index
//   timeout_err         sticky: a layer watchdog expired
//   frame_count         completed frames, wraps at 2^16
module rnn_frame_ctrl #(
   parameter int FIXED       = 32,
   parameter int INPUT_SIZE  = 42,
   parameter int OUTPUT_SIZE = 22,
   parameter int NUM_LAYERS  = 6,
   parameter int TIMEOUT     = 4096
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [FIXED-1:0]              in_data,
   input  logic                          in_last,
   output logic [INPUT_SIZE*FIXED-1:0]   feature_vec,
   output logic [NUM_LAYERS-1:0]         layer_start,
   input  logic [NUM_LAYERS-1:0]         layer_done,
   input  logic [OUTPUT_SIZE*FIXED-1:0]  gains_in,
   input  logic [FIXED-1:0]              vad_in,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [FIXED-1:0]              out_data,
   output logic                          out_last,
   output logic [FIXED-1:0]              vad_out,
   output logic                          busy,
   input  logic                          err_clr,
   output logic                          len_err,
   output logic                          timeout_err,
   output logic [15:0]                   frame_count
);

   localparam int IW = (INPUT_SIZE  > 1) ? $clog2(INPUT_SIZE)  : 1;
   localparam int OW = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1;
   localparam int KW = (NUM_LAYERS  > 1) ? $clog2(NUM_LAYERS)  : 1;
   localparam int WW = $clog2(TIMEOUT + 1);

   localparam logic [IW-1:0] IN_MAX    = IW'(INPUT_SIZE - 1);
   localparam logic [OW-1:0] OUT_MAX   = OW'(OUTPUT_SIZE - 1);
   localparam logic [KW-1:0] LAYER_MAX = KW'(NUM_LAYERS - 1);
   localparam logic [WW-1:0] WD_LIMIT  = WW'(TIMEOUT);

   typedef enum logic [1:0] {
      ST_LOAD  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t state, state_next;

   logic [IW-1:0]                  in_idx;
   logic [OW-1:0]                  out_idx;
   logic [KW-1:0]                  layer_idx;
   logic [WW-1:0]                  wdog;
   logic [WW-1:0]                  wdog_inc;
   logic                           first;     // current cycle is the start cycle of layer_idx
   logic [OUTPUT_SIZE*FIXED-1:0]   gain_reg;

   logic in_fire, load_end, len_evt;
   logic layer_ack, last_layer, expire;
   logic out_fire, drain_end;

   assign in_fire    = in_valid & in_ready;
   assign load_end   = in_fire && (in_idx == IN_MAX);
   assign len_evt    = in_fire && (in_idx != IN_MAX) && in_last;

   // Done is only honoured for the active layer and never on its start cycle.
   assign layer_ack  = (state == ST_RUN) && !first && layer_done[layer_idx];
   assign last_layer = (layer_idx == LAYER_MAX);
   assign wdog_inc   = wdog + 1'b1;
   // Expiry is the cycle on which the counter would reach TIMEOUT; a done
   // arriving on that same cycle takes priority.
   assign expire     = (state == ST_RUN) && !first && !layer_ack && (wdog_inc == WD_LIMIT);

   assign out_fire   = out_valid & out_ready;
   assign drain_end  = out_fire && (out_idx == OUT_MAX);

   assign out_data   = gain_reg[out_idx*FIXED +: FIXED];

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= ST_LOAD;
      else     state <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      unique case (state)
         ST_LOAD:  if (load_end) state_next = ST_RUN;
         ST_RUN: begin
            if (layer_ack && last_layer) state_next = ST_DRAIN;
            else if (expire)             state_next = ST_LOAD;
         end
         ST_DRAIN: if (drain_end) state_next = ST_LOAD;
         default:  state_next = ST_LOAD;
      endcase
   end

   // Output decode
   always_comb begin
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      out_last    = 1'b0;
      busy        = 1'b0;
      layer_start = '0;
      unique case (state)
         ST_LOAD: in_ready = 1'b1;
         ST_RUN: begin
            busy = 1'b1;
            if (first) layer_start[layer_idx] = 1'b1;
         end
         ST_DRAIN: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            out_last  = (out_idx == OUT_MAX);
         end
         default: ;
      endcase
   end

   // Datapath, counters and sticky flags
   always_ff @(posedge clk) begin
      if (rst) begin
         feature_vec <= '0;
         gain_reg    <= '0;
         vad_out     <= '0;
         in_idx      <= '0;
         out_idx     <= '0;
         layer_idx   <= '0;
         wdog        <= '0;
         first       <= 1'b0;
         frame_count <= '0;
         len_err     <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         unique case (state)
            ST_LOAD: begin
               if (in_fire) begin
                  feature_vec[in_idx*FIXED +: FIXED] <= in_data;
                  if (in_idx == IN_MAX) begin
                     in_idx    <= '0;
                     layer_idx <= '0;
                     first     <= 1'b1;
                     wdog      <= '0;
                  end else if (in_last) begin
                     in_idx <= '0;
                  end else begin
                     in_idx <= in_idx + 1'b1;
                  end
               end
            end
            ST_RUN: begin
               first <= 1'b0;
               wdog  <= wdog_inc;
               if (layer_ack) begin
                  if (last_layer) begin
                     gain_reg <= gains_in;
                     vad_out  <= vad_in;
                     out_idx  <= '0;
                  end else begin
                     layer_idx <= layer_idx + 1'b1;
                     first     <= 1'b1;
                     wdog      <= '0;
                  end
               end else if (expire) begin
                  in_idx <= '0;
               end
            end
            ST_DRAIN: begin
               if (out_fire) begin
                  if (out_idx == OUT_MAX) begin
                     out_idx     <= '0;
                     frame_count <= frame_count + 1'b1;
                  end else begin
                     out_idx <= out_idx + 1'b1;
                  end
               end
            end
            default: ;
         endcase

         // A fresh error outranks a simultaneous clear.
         len_err     <= (len_err     & ~err_clr) | len_evt;
         timeout_err <= (timeout_err & ~err_clr) | expire;
      end
   end

endmodule

// File: tb/tb_rnn_frame_ctrl.sv
// tb_rnn_frame_ctrl -- self-checking bench for rnn_frame_ctrl (TIMEOUT = 16).
//
// A table of frame scenarios drives loads, layer responses and output
// backpressure; hand-written sequences cover simultaneous done/expiry,
// error clear collisions and reset during drain.
module tb_rnn_frame_ctrl;

   localparam int FIXED = 32;
   localparam int IN_N  = 42;
   localparam int OUT_N = 22;
   localparam int NL    = 6;
   localparam int TO    = 16;

   logic                     clk = 1'b0;
   logic                     rst;
   logic                     in_valid;
   logic                     in_ready;
   logic [FIXED-1:0]         in_data;
   logic                     in_last;
   logic [IN_N*FIXED-1:0]    feature_vec;
   logic [NL-1:0]            layer_start;
   logic [NL-1:0]            layer_done;
   logic [OUT_N*FIXED-1:0]   gains_in;
   logic [FIXED-1:0]         vad_in;
   logic                     out_valid;
   logic                     out_ready = 1'b1;
   logic [FIXED-1:0]         out_data;
   logic                     out_last;
   logic [FIXED-1:0]         vad_out;
   logic                     busy;
   logic                     err_clr;
   logic                     len_err;
   logic                     timeout_err;
   logic [15:0]              frame_count;

   logic [NL-1:0] resp_done = '0;
   logic [NL-1:0] inj_done  = '0;
   assign layer_done = resp_done | inj_done;

   rnn_frame_ctrl #(
      .FIXED       (FIXED),
      .INPUT_SIZE  (IN_N),
      .OUTPUT_SIZE (OUT_N),
      .NUM_LAYERS  (NL),
      .TIMEOUT     (TO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .in_last     (in_last),
      .feature_vec (feature_vec),
      .layer_start (layer_start),
      .layer_done  (layer_done),
      .gains_in    (gains_in),
      .vad_in      (vad_in),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_last    (out_last),
      .vad_out     (vad_out),
      .busy        (busy),
      .err_clr     (err_clr),
      .len_err     (len_err),
      .timeout_err (timeout_err),
      .frame_count (frame_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int passed = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got === exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
   endtask

   // ---------------- layer responder ----------------
   typedef struct {
      int k;
      int c;
   } start_t;
   start_t starts_q[$];

   int delay    = 3;
   int withhold = -1;
   bit resp_pend = 1'b0;
   int resp_k    = 0;
   int resp_cnt  = 0;

   always begin
      @(posedge clk);
      #1;
      resp_done = '0;
      if (resp_pend) begin
         if (resp_cnt == 1) begin
            if (resp_k != withhold) resp_done[resp_k] = 1'b1;
            resp_pend = 1'b0;
         end else begin
            resp_cnt--;
         end
      end
      if (|layer_start) begin
         int k;
         k = 0;
         check("start_onehot", 64'($onehot(layer_start)), 64'd1);
         for (int i = 0; i < NL; i++) if (layer_start[i]) k = i;
         starts_q.push_back('{k, cyc});
         if (delay == 0) begin
            if (k != withhold) resp_done[k] = 1'b1;
         end else begin
            resp_pend = 1'b1;
            resp_k    = k;
            resp_cnt  = delay;
         end
      end
   end

   // ---------------- out_ready driver ----------------
   bit rdy_toggle = 1'b0;
   always begin
      @(posedge clk);
      #1;
      if (rdy_toggle) out_ready = ~out_ready;
      else            out_ready = 1'b1;
   end

   // ---------------- output collector ----------------
   logic [FIXED-1:0] outs_q[$];
   bit               lasts_q[$];
   bit               prev_stall = 1'b0;
   logic [FIXED-1:0] prev_data  = '0;

   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("stall_valid_hold", 64'(out_valid), 64'd1);
            check("stall_data_hold", 64'(out_data), 64'(prev_data));
         end
         if (out_valid && out_ready) begin
            outs_q.push_back(out_data);
            lasts_q.push_back(out_last);
         end
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
      end
   end

   // ---------------- scenario table ----------------
   typedef struct {
      int nw;      // words sent
      int lastf;   // in_last on final sent word
      int dly;     // done delay after start (0 = on start cycle)
      int wh;      // layer whose done is withheld (-1 none)
      int tog;     // out_ready toggles
      int clr;     // pulse err_clr before the frame
      int e_len;   // expected len_err afterwards
      int e_to;    // expected timeout_err afterwards
      int e_done;  // frame expected to complete
      int e_st;    // expected number of start pulses
      int e_tol;   // layer expected to time out (-1 none)
   } scen_t;

   scen_t tbl[7];

   logic [FIXED-1:0] fv_model [IN_N];
   int               exp_fc  = 0;
   logic [FIXED-1:0] exp_vad = '0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_words(input int n, input int lastf, input logic [FIXED-1:0] fbase,
                             input bit clr_last, output int tlast);
      tlast = 0;
      for (int i = 0; i < n; i++) begin
         int w;
         w = 0;
         while (!in_ready && w < 200) begin
            tick();
            w++;
         end
         if (!in_ready) check("in_ready_wait", 64'd0, 64'd1);
         in_valid    = 1'b1;
         in_data     = fbase + FIXED'(i + 1);
         in_last     = (lastf != 0) && (i == n - 1);
         err_clr     = clr_last && (i == n - 1);
         fv_model[i] = in_data;
         tlast       = cyc;
         tick();
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      err_clr  = 1'b0;
   endtask

   task automatic wait_idle(output int rc);
      int n;
      n = 0;
      while (!in_ready && n < 3000) begin
         tick();
         n++;
      end
      if (!in_ready) check("idle_wait_expired", 64'd0, 64'd1);
      rc = cyc;
   endtask

   task automatic set_results(input logic [FIXED-1:0] gbase, input logic [FIXED-1:0] vad);
      for (int i = 0; i < OUT_N; i++) gains_in[i*FIXED +: FIXED] = gbase + FIXED'(i);
      vad_in = vad;
   endtask

   task automatic check_outputs(input int n_exp, input logic [FIXED-1:0] gbase);
      check("out_count", 64'(outs_q.size()), 64'(n_exp));
      for (int i = 0; i < outs_q.size() && i < n_exp; i++) begin
         check($sformatf("out_word%0d", i), 64'(outs_q[i]), 64'(gbase + FIXED'(i)));
         check($sformatf("out_last%0d", i), 64'(lasts_q[i]), 64'(i == n_exp - 1));
      end
   endtask

   task automatic check_features();
      for (int i = 0; i < IN_N; i++)
         check($sformatf("feature_word%0d", i), 64'(feature_vec[i*FIXED +: FIXED]), 64'(fv_model[i]));
   endtask

   task automatic run_scen(input scen_t s, input int idx);
      logic [FIXED-1:0] fbase, gbase, vad;
      int tlast, rc;
      fbase = FIXED'(idx * 256);
      gbase = FIXED'((idx + 1) * 256);
      vad   = FIXED'(127 + idx);
      if (s.clr != 0) begin
         err_clr = 1'b1;
         tick();
         err_clr = 1'b0;
      end
      delay      = s.dly;
      withhold   = s.wh;
      rdy_toggle = (s.tog != 0);
      set_results(gbase, vad);
      starts_q.delete();
      outs_q.delete();
      lasts_q.delete();
      send_words(s.nw, s.lastf, fbase, 1'b0, tlast);
      wait_idle(rc);
      rdy_toggle = 1'b0;
      if (s.e_done != 0) begin
         exp_fc++;
         exp_vad = vad;
      end
      check($sformatf("s%0d_frame_count", idx), 64'(frame_count), 64'(exp_fc[15:0]));
      check($sformatf("s%0d_len_err", idx), 64'(len_err), 64'(s.e_len));
      check($sformatf("s%0d_timeout_err", idx), 64'(timeout_err), 64'(s.e_to));
      check($sformatf("s%0d_vad_out", idx), 64'(vad_out), 64'(exp_vad));
      check($sformatf("s%0d_busy_idle", idx), 64'(busy), 64'd0);
      check($sformatf("s%0d_start_count", idx), 64'(starts_q.size()), 64'(s.e_st));
      for (int j = 0; j < starts_q.size() && j < s.e_st; j++) begin
         check($sformatf("s%0d_start%0d_layer", idx, j), 64'(starts_q[j].k), 64'(j));
         if (j == 0)
            check($sformatf("s%0d_start0_cycle", idx), 64'(starts_q[0].c - tlast), 64'd1);
         else
            check($sformatf("s%0d_start%0d_gap", idx, j), 64'(starts_q[j].c - starts_q[j-1].c),
                  64'(s.dly + 1));
      end
      if (s.e_tol >= 0 && starts_q.size() > s.e_tol)
         check($sformatf("s%0d_timeout_gap", idx), 64'(rc - starts_q[s.e_tol].c), 64'(TO));
      check_outputs((s.e_done != 0) ? OUT_N : 0, gbase);
      check_features();
   endtask

   initial begin
      int tlast, rc, n, s1;

      tbl[0] = '{42, 1, 3, -1, 0, 0, 0, 0, 1, 6, -1};  // nominal
      tbl[1] = '{42, 0, 3, -1, 1, 0, 0, 0, 1, 6, -1};  // output backpressure
      tbl[2] = '{11, 1, 3, -1, 0, 0, 1, 0, 0, 0, -1};  // short frame
      tbl[3] = '{42, 0, 3, -1, 0, 0, 1, 0, 1, 6, -1};  // full frame, len_err sticky
      tbl[4] = '{42, 0, 3,  2, 0, 1, 0, 1, 0, 3,  2};  // layer 2 never done
      tbl[5] = '{42, 1, 1, -1, 0, 0, 0, 1, 1, 6, -1};  // done on first waiting cycle
      tbl[6] = '{42, 0, 0, -1, 0, 1, 0, 1, 0, 1,  0};  // done only on start cycle

      for (int i = 0; i < IN_N; i++) fv_model[i] = '0;
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;
      in_last  = 1'b0;
      gains_in = '0;
      vad_in   = '0;
      err_clr  = 1'b0;
      repeat (3) tick();
      rst = 1'b0;

      // Reset state
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_last", 64'(out_last), 64'd0);
      check("rst_out_data", 64'(out_data), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_layer_start", 64'(layer_start), 64'd0);
      check("rst_len_err", 64'(len_err), 64'd0);
      check("rst_timeout_err", 64'(timeout_err), 64'd0);
      check("rst_vad_out", 64'(vad_out), 64'd0);
      check("rst_frame_count", 64'(frame_count), 64'd0);
      check("rst_feature_any", 64'(|feature_vec), 64'd0);

      for (int i = 0; i < 7; i++) run_scen(tbl[i], i);

      // Wrong-layer done ignored; done on the expiry cycle wins.
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("b_clr_timeout", 64'(timeout_err), 64'd0);
      delay    = 3;
      withhold = 1;
      set_results(32'h900, 32'h55);
      starts_q.delete();
      outs_q.delete();
      lasts_q.delete();
      send_words(IN_N, 1, 32'h5000, 1'b0, tlast);
      n = 0;
      while (starts_q.size() < 2 && n < 200) begin
         tick();
         n++;
      end
      if (starts_q.size() < 2) begin
         check("b_layer1_start_seen", 64'd0, 64'd1);
         s1 = cyc;
      end else begin
         s1 = starts_q[1].c;
      end
      while (cyc < s1 + TO - 1) begin
         inj_done = '0;
         if (cyc >= s1 + 1 && cyc <= s1 + 10) inj_done[4] = 1'b1;
         if (cyc == s1 + 5) check("b_busy_running", 64'(busy), 64'd1);
         if (cyc == s1 + TO - 2) check("b_no_early_timeout", 64'(timeout_err), 64'd0);
         tick();
      end
      inj_done    = '0;
      inj_done[1] = 1'b1;
      tick();
      inj_done = '0;
      withhold = -1;
      wait_idle(rc);
      exp_fc++;
      exp_vad = 32'h55;
      check("b_start_count", 64'(starts_q.size()), 64'd6);
      if (starts_q.size() > 2) begin
         check("b_start2_layer", 64'(starts_q[2].k), 64'd2);
         check("b_start2_cycle", 64'(starts_q[2].c - s1), 64'(TO));
      end
      check("b_timeout_err", 64'(timeout_err), 64'd0);
      check("b_frame_count", 64'(frame_count), 64'(exp_fc[15:0]));
      check("b_vad_out", 64'(vad_out), 64'(exp_vad));
      check_outputs(OUT_N, 32'h900);

      // Length error in the same cycle as err_clr keeps the flag.
      starts_q.delete();
      send_words(3, 1, 32'h6000, 1'b1, tlast);
      check("d_len_err_vs_clr", 64'(len_err), 64'd1);
      check("d_no_start", 64'(starts_q.size()), 64'd0);

      // Reset while draining.
      set_results(32'hA00, 32'h66);
      outs_q.delete();
      lasts_q.delete();
      send_words(IN_N, 1, 32'h7000, 1'b0, tlast);
      n = 0;
      while (outs_q.size() < 5 && n < 500) begin
         tick();
         n++;
      end
      check("c_len_err_before_rst", 64'(len_err), 64'd1);
      check("c_in_drain", 64'(out_valid), 64'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_fc  = 0;
      exp_vad = '0;
      for (int i = 0; i < IN_N; i++) fv_model[i] = '0;
      check("c_outs_before_rst", 64'(outs_q.size()), 64'd5);
      check("c_out_valid", 64'(out_valid), 64'd0);
      check("c_in_ready", 64'(in_ready), 64'd1);
      check("c_vad_out", 64'(vad_out), 64'd0);
      check("c_frame_count", 64'(frame_count), 64'd0);
      check("c_len_err", 64'(len_err), 64'd0);
      check("c_timeout_err", 64'(timeout_err), 64'd0);
      check("c_busy", 64'(busy), 64'd0);
      check_features();

      // Operation resumes normally after the reset.
      run_scen(tbl[0], 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
